// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : apu_frame_sequencer
// Purpose  : APU frame sequencer. Counts ACLK1 cycles and issues the
//            active-low quarter-frame (n_LFO1) and half-frame (n_LFO2)
//            strobes. Owns the $4017 mode / IRQ-inhibit register and the
//            frame interrupt flag.
// Revision : 1.0 - initial release
// ============================================================================
module apu_frame_sequencer #(
  parameter int CNT_W    = 15,
  parameter int STEP1    = 3728,
  parameter int STEP2    = 7456,
  parameter int STEP3    = 11185,
  parameter int STEP4    = 14914,
  parameter int STEP5    = 18640,
  parameter int WR_DELAY = 2
) (
  input  logic       ACLK1,
  input  logic       n_RES,
  input  logic       W4017,
  input  logic [7:0] DB,
  input  logic       R4015,
  output logic       n_LFO1,
  output logic       n_LFO2,
  output logic       FRAME_INT,
  output logic       MODE
);

  // The delay counter only has to hold WR_DELAY-1.
  localparam int               DLY_W    = (WR_DELAY > 1) ? $clog2(WR_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(WR_DELAY - 1);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             mode_q, mode_d;
  logic             inh_q, inh_d;
  logic             irq_q, irq_d;
  logic             pend_q, pend_d;
  logic             force_q, force_d;
  logic             lfo1_n_q, lfo2_n_q;

  logic [CNT_W-1:0] last_step;
  logic             restart;
  logic             q_hit;
  logic             h_hit;
  logic             quarter;
  logic             half;
  logic             irq_set;

  // Only the mode and inhibit bits of the write data are meaningful.
  logic [5:0] unused_db_bits;
  assign unused_db_bits = DB[5:0];

  // Step decode, restart arbitration, $4017 loading and IRQ priority.
  always_comb begin
    // A fresh write in the restart cycle re-arms the delay instead.
    restart   = pend_q && (dly_q == '0) && !W4017;
    last_step = mode_q ? S5 : S4;

    // The last step of either mode is both a quarter and a half frame,
    // which also silences STEP4 in 5-step mode.
    q_hit = (cnt_q == S1) || (cnt_q == S2) || (cnt_q == S3) || (cnt_q == last_step);
    h_hit = (cnt_q == S2) || (cnt_q == last_step);

    // A restart masks any step match; the mode-1 pulse comes from force_q
    // in the cycle after the restart, when cnt is already 0.
    quarter = force_q || (q_hit && !restart);
    half    = force_q || (h_hit && !restart);
    irq_set = !restart && (cnt_q == S4) && !mode_q && !inh_q;
    force_d = restart && mode_q;

    // >= keeps cnt bounded if the mode drops to 4-step past STEP4.
    if (restart || (cnt_q >= last_step)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    mode_d = mode_q;
    inh_d  = inh_q;
    pend_d = pend_q;
    dly_d  = dly_q;
    if (W4017) begin
      mode_d = DB[7];
      inh_d  = DB[6];
      pend_d = 1'b1;
      dly_d  = DLY_INIT;
    end else if (restart) begin
      pend_d = 1'b0;
    end else if (pend_q) begin
      dly_d = dly_q - DLY_W'(1);
    end

    // Write-clear beats set, set beats status-read clear.
    if (W4017 && DB[6]) begin
      irq_d = 1'b0;
    end else if (irq_set) begin
      irq_d = 1'b1;
    end else if (R4015) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // State and registered strobe outputs, synchronous active-low reset.
  always_ff @(posedge ACLK1) begin
    if (!n_RES) begin
      cnt_q    <= '0;
      dly_q    <= '0;
      mode_q   <= 1'b0;
      inh_q    <= 1'b0;
      irq_q    <= 1'b0;
      pend_q   <= 1'b0;
      force_q  <= 1'b0;
      lfo1_n_q <= 1'b1;
      lfo2_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      mode_q   <= mode_d;
      inh_q    <= inh_d;
      irq_q    <= irq_d;
      pend_q   <= pend_d;
      force_q  <= force_d;
      lfo1_n_q <= ~quarter;
      lfo2_n_q <= ~half;
    end
  end

  assign n_LFO1    = lfo1_n_q;
  assign n_LFO2    = lfo2_n_q;
  assign FRAME_INT = irq_q;
  assign MODE      = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_frame_sequencer
// Purpose  : Self-checking bench for apu_frame_sequencer. A reference model
//            predicts the outputs of every cycle into a scoreboard queue;
//            a monitor pops and compares. Strobe / IRQ timestamps are also
//            logged and checked against fixed cycle numbers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_frame_sequencer;

  localparam int CNT_W    = 15;
  localparam int STEP1    = 3728;
  localparam int STEP2    = 7456;
  localparam int STEP3    = 11185;
  localparam int STEP4    = 14914;
  localparam int STEP5    = 18640;
  localparam int WR_DELAY = 2;

  logic       clk = 1'b0;
  logic       n_res = 1'b0;
  logic       w4017 = 1'b0;
  logic [7:0] db = 8'h00;
  logic       r4015 = 1'b0;
  logic       n_lfo1, n_lfo2, frame_int, mode;

  always #5 clk = ~clk;

  apu_frame_sequencer #(
    .CNT_W(CNT_W), .STEP1(STEP1), .STEP2(STEP2), .STEP3(STEP3),
    .STEP4(STEP4), .STEP5(STEP5), .WR_DELAY(WR_DELAY)
  ) dut (
    .ACLK1    (clk),
    .n_RES    (n_res),
    .W4017    (w4017),
    .DB       (db),
    .R4015    (r4015),
    .n_LFO1   (n_lfo1),
    .n_LFO2   (n_lfo2),
    .FRAME_INT(frame_int),
    .MODE     (mode)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Scoreboard: {n_LFO1, n_LFO2, FRAME_INT, MODE} expected after each edge.
  logic [3:0] exp_q[$];

  // Reference model: frame position, register bits, absolute restart time.
  longint m_t       = 0;
  longint m_restart = -1;
  int     m_pos     = 0;
  bit     m_mode, m_inh, m_irq, m_force;
  longint tk        = 0;   // edges since the last reset edge

  function automatic bit is_quarter(int p, bit md);
    return (p == STEP1) || (p == STEP2) || (p == STEP3) ||
           (!md && p == STEP4) || (md && p == STEP5);
  endfunction

  function automatic bit is_half(int p, bit md);
    return (p == STEP2) || (!md && p == STEP4) || (md && p == STEP5);
  endfunction

  task automatic model_edge(input bit w, input logic [7:0] d, input bit r, input bit nres);
    bit q, h, rs, set;
    m_t++;
    if (!nres) begin
      m_pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_force = 0; m_restart = -1;
      q = 0; h = 0;
    end else begin
      rs  = (m_restart == m_t) && !w;
      q   = m_force || (!rs && is_quarter(m_pos, m_mode));
      h   = m_force || (!rs && is_half(m_pos, m_mode));
      set = !rs && (m_pos == STEP4) && !m_mode && !m_inh;
      if (w && d[6])   m_irq = 0;
      else if (set)    m_irq = 1;
      else if (r)      m_irq = 0;
      m_force = rs && m_mode;
      if (rs)                                 m_pos = 0;
      else if (m_pos >= (m_mode ? STEP5 : STEP4)) m_pos = 0;
      else                                    m_pos = m_pos + 1;
      if (w) begin
        m_mode = d[7]; m_inh = d[6]; m_restart = m_t + WR_DELAY;
      end else if (rs) begin
        m_restart = -1;
      end
    end
    exp_q.push_back({~q, ~h, m_irq, m_mode});
  endtask

  // Drive one cycle of stimulus and predict the result of the next edge.
  task automatic tick(input bit w, input logic [7:0] d, input bit r, input bit nres);
    @(negedge clk);
    w4017 = w; db = d; r4015 = r; n_res = nres;
    model_edge(w, d, r, nres);
    if (!nres) tk = 0; else tk++;
  endtask

  task automatic idle(input int n, input int r_odds);
    for (int i = 0; i < n; i++)
      tick(1'b0, 8'($urandom), (r_odds > 0) && ($urandom_range(0, r_odds - 1) == 0), 1'b1);
  endtask

  task automatic sync_out();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input longint got, input longint req);
    n_chk++;
    if (got == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, req);
  endtask

  task automatic chk_log(input string name, input longint got[$], input longint req[$]);
    chk({name, " count"}, got.size(), req.size());
    foreach (req[i])
      chk($sformatf("%s[%0d]", name, i), (i < got.size()) ? got[i] : -1, req[i]);
  endtask

  // Monitor: cycle counter, event logs and scoreboard comparison.
  longint cyc = 0;
  longint lfo1_log[$], lfo2_log[$], irq_log[$];
  logic   prev_fi = 1'b0;

  task automatic clear_logs();
    lfo1_log.delete(); lfo2_log.delete(); irq_log.delete();
  endtask

  always begin
    logic [3:0] e;
    @(posedge clk);
    if (n_res !== 1'b1) cyc = 0; else cyc++;
    #1;
    if (n_lfo1 === 1'b0) lfo1_log.push_back(cyc);
    if (n_lfo2 === 1'b0) lfo2_log.push_back(cyc);
    if (frame_int === 1'b1 && prev_fi !== 1'b1) irq_log.push_back(cyc);
    prev_fi = frame_int;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if ({n_lfo1, n_lfo2, frame_int, mode} === e) n_pass++;
      else $display("FAIL outputs cyc=%0d {n_LFO1,n_LFO2,FRAME_INT,MODE} got %b required %b",
                    cyc, {n_lfo1, n_lfo2, frame_int, mode}, e);
    end
  end

  initial begin
    longint e, ec, e1;
    longint ex1[$], ex2[$], none[$];

    // Reset
    repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0);
    sync_out();
    chk("reset n_LFO1", n_lfo1, 1);
    chk("reset n_LFO2", n_lfo2, 1);
    chk("reset FRAME_INT", frame_int, 0);
    chk("reset MODE", mode, 0);
    clear_logs();

    // Free run in 4-step mode; status read lands on cnt == STEP4.
    idle(STEP4, 0);
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    idle(18650 - (STEP4 + 1), 0);
    sync_out();
    ex1 = {}; ex1.push_back(3729); ex1.push_back(7457); ex1.push_back(11186);
    ex1.push_back(14915); ex1.push_back(14915 + 3729);
    chk_log("mode0 n_LFO1 cycles", lfo1_log, ex1);
    ex2 = {}; ex2.push_back(7457); ex2.push_back(14915);
    chk_log("mode0 n_LFO2 cycles", lfo2_log, ex2);
    ex1 = {}; ex1.push_back(14915);
    chk_log("FRAME_INT rise (set beats R4015)", irq_log, ex1);
    chk("FRAME_INT held", frame_int, 1);

    // Restart in 4-step mode; plain R4015 clear; write-clear race at STEP4.
    clear_logs();
    tick(1'b1, {2'b00, 6'($urandom)}, 1'b0, 1'b1);
    e = tk;
    chk("FRAME_INT kept by DB6=0 write", frame_int, 1);
    idle(7000, 0);
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    sync_out();
    chk("R4015 clears FRAME_INT", frame_int, 0);
    idle(14917 - 7001 - 1, 0);
    tick(1'b1, {2'b01, 6'($urandom)}, 1'b0, 1'b1);
    ec = tk;
    sync_out();
    chk("W4017 DB6 beats IRQ set", frame_int, 0);
    ex1 = {}; ex1.push_back(e + 3 + STEP1); ex1.push_back(e + 3 + STEP2);
    ex1.push_back(e + 3 + STEP3); ex1.push_back(e + 3 + STEP4);
    chk_log("restart mode0 n_LFO1 cycles", lfo1_log, ex1);
    chk_log("no FRAME_INT rise in race frame", irq_log, none);

    // Inhibited frame: STEP4 must not raise FRAME_INT.
    clear_logs();
    idle(2 + STEP4 + 5, 200);
    sync_out();
    ex1 = {}; ex1.push_back(ec + 3 + STEP1); ex1.push_back(ec + 3 + STEP2);
    ex1.push_back(ec + 3 + STEP3); ex1.push_back(ec + 3 + STEP4);
    chk_log("inhibit n_LFO1 cycles", lfo1_log, ex1);
    chk_log("inhibit FRAME_INT rises", irq_log, none);

    // Rewrite while pending: 0x00 then 0x80 -> one restart, forced pulse.
    clear_logs();
    tick(1'b1, {2'b00, 6'($urandom)}, 1'b0, 1'b1);
    tick(1'b1, {2'b10, 6'($urandom)}, 1'b0, 1'b1);
    e1 = tk;
    idle(2 + STEP5 + 5, 200);
    sync_out();
    ex1 = {}; ex1.push_back(e1 + WR_DELAY + 1); ex1.push_back(e1 + 3 + STEP1);
    ex1.push_back(e1 + 3 + STEP2); ex1.push_back(e1 + 3 + STEP3);
    ex1.push_back(e1 + 3 + STEP5);
    chk_log("mode1 n_LFO1 cycles", lfo1_log, ex1);
    ex2 = {}; ex2.push_back(e1 + WR_DELAY + 1); ex2.push_back(e1 + 3 + STEP2);
    ex2.push_back(e1 + 3 + STEP5);
    chk_log("mode1 n_LFO2 cycles", lfo2_log, ex2);
    chk_log("mode1 FRAME_INT rises", irq_log, none);
    chk("MODE after 0x80", mode, 1);

    // Mid-frame reset while the model says cnt == STEP2.
    for (int i = 0; i < 20000 && m_pos != STEP2; i++) idle(1, 0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    sync_out();
    chk("mid reset n_LFO1", n_lfo1, 1);
    chk("mid reset n_LFO2", n_lfo2, 1);
    chk("mid reset FRAME_INT", frame_int, 0);
    chk("mid reset MODE", mode, 0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    clear_logs();
    idle(STEP1 + 1 + 5, 0);
    sync_out();
    ex1 = {}; ex1.push_back(STEP1 + 1);
    chk_log("post-reset n_LFO1 cycles", lfo1_log, ex1);

    // Random writes and status reads, scoreboard only.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 299) == 0, 8'($urandom), $urandom_range(0, 39) == 0, 1'b1);
    sync_out();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
